// File: rtl/midgap_dgwclk_seq.sv
// Staggered wake-up sequencer for NCH gated-clock channels.
// Each channel runs OFF/PEND/ON and owns one ICG feeding a left and a right clock buffer.
// Wake-ups are spaced by at least STAGGER cycles. Turn-offs honour a HOLD-cycle minimum on-time.
module midgap_dgwclk_seq #(
  parameter int unsigned NCH     = 16,
  parameter int unsigned STAGGER = 2,
  parameter int unsigned HOLD    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           SE,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] DGWClkLeftNet,
  output logic [NCH-1:0] DGWClkRightNet,
  output logic [NCH-1:0] en_state,
  output logic           busy
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] HoldCnt    = CntW'(HOLD);
  localparam logic [CntW-1:0] StaggerLd  = CntW'(STAGGER - 1);

  typedef enum logic [1:0] {
    Off  = 2'd0,
    Pend = 2'd1,
    On   = 2'd2
  } chState_e;

  chState_e        chState [NCH];
  logic [CntW-1:0] onCnt   [NCH];
  logic [CntW-1:0] staggerCnt;
  logic [NCH-1:0]  grantVec;
  logic [NCH-1:0]  pendNext;
  logic            grantFound;

  // Single grant per cycle to the lowest-index pending channel that still requests
  always_comb begin
    grantVec   = '0;
    grantFound = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!grantFound && (staggerCnt == '0) && (chState[i] == Pend) && req[i]) begin
        grantVec[i] = 1'b1;
        grantFound  = 1'b1;
      end
    end
  end

  // Channels that will be pending after this edge; feeds the registered busy flag
  always_comb begin
    pendNext = '0;
    for (int i = 0; i < NCH; i++) begin
      pendNext[i] = req[i] && ((chState[i] == Off) || ((chState[i] == Pend) && !grantVec[i]));
    end
  end

  // Per-channel FSMs, hold counters, stagger counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        chState[i] <= Off;
        onCnt[i]   <= '0;
      end
      en_state   <= '0;
      busy       <= 1'b0;
      staggerCnt <= '0;
    end else begin
      if (|grantVec) begin
        staggerCnt <= StaggerLd;
      end else if (staggerCnt != '0) begin
        staggerCnt <= staggerCnt - CntW'(1);
      end

      busy <= |pendNext;

      for (int i = 0; i < NCH; i++) begin
        case (chState[i])
          Off: begin
            if (req[i]) chState[i] <= Pend;
          end
          Pend: begin
            if (!req[i]) begin
              chState[i] <= Off;
            end else if (grantVec[i]) begin
              chState[i]  <= On;
              onCnt[i]    <= '0;
              en_state[i] <= 1'b1;
            end
          end
          On: begin
            if (!req[i] && (onCnt[i] >= HoldCnt)) begin
              chState[i]  <= Off;
              onCnt[i]    <= '0;
              en_state[i] <= 1'b0;
            end else if (onCnt[i] < HoldCnt) begin
              onCnt[i] <= onCnt[i] + CntW'(1);
            end
          end
          default: begin
            chState[i]  <= Off;
            onCnt[i]    <= '0;
            en_state[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Clock tree per channel: one ICG, two balanced buffers
  for (genvar g = 0; g < NCH; g++) begin : gCh
    logic gatedClk;

    PREICG_X0P5B_A12TR uIcg (
      .CK (clk),
      .E  (en_state[g]),
      .SE (SE),
      .ECK(gatedClk)
    );

    BUFH_X3M_A12TR uBufLeft (
      .A(gatedClk),
      .Y(DGWClkLeftNet[g])
    );

    BUFH_X3M_A12TR uBufRight (
      .A(gatedClk),
      .Y(DGWClkRightNet[g])
    );
  end

endmodule

// Behavioural view of the latch-based integrated clock gate
module PREICG_X0P5B_A12TR (
  input  logic CK,
  input  logic E,
  input  logic SE,
  output logic ECK
);

  logic enLat;

  // Enable is captured while CK is low so the gated pulse is always whole
  always_latch begin
    if (!CK) enLat <= E | SE;
  end

  assign ECK = CK & enLat;

endmodule

// Behavioural view of the clock buffer
module BUFH_X3M_A12TR (
  input  logic A,
  output logic Y
);

  assign Y = A;

endmodule
